dual_port_write_decoder: RTL and testbench

DUAL_PORT_WRITE_DECODER -- requirements
Module: dual_port_write_decoder

---
 rtl/dual_port_write_decoder.sv | 111 +++++++++++
 tb/tb_dual_port_write_decoder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dual_port_write_decoder.sv
// Two-port register-file write decoder: merges port A/B writes into registered load strobes.
// A same-register A/B collision defers B through a one-entry hold buffer.
// Optional feature macro ZERO_REG_WRITE_PROTECT_EN drops every write aimed at register 0.
module dual_port_write_decoder #(
  parameter  int SEL_W  = 5,
  parameter  int DATA_W = 32,
  localparam int NREG   = 2 ** SEL_W
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [SEL_W-1:0]  SelA,
  input  logic              WenA,
  input  logic [DATA_W-1:0] DataA,
  input  logic [SEL_W-1:0]  SelB,
  input  logic              WenB,
  input  logic [DATA_W-1:0] DataB,
  output logic              ReadyB,
  output logic [NREG-1:0]   Load_Out,
  output logic [NREG-1:0]   Load_Src,
  output logic [DATA_W-1:0] DataA_Out,
  output logic [DATA_W-1:0] DataB_Out,
  output logic [7:0]        Conflict_Cnt
);

  // state | meaning
  // EMPTY | hold buffer free, port B accepted (ReadyB=1)
  // HELD  | deferred B write waiting in hold buffer, port B stalled (ReadyB=0)
  typedef enum logic {EMPTY, HELD} state_t;

  state_t             state;
  logic [SEL_W-1:0]   hold_sel;
  logic [DATA_W-1:0]  hold_data;

  logic               wen_a;
  logic               wen_b;
  logic               collide;
  logic               a_on_hold;
  logic [NREG-1:0]    mask_a;
  logic [NREG-1:0]    mask_b;
  logic [NREG-1:0]    mask_h;

  function automatic logic [NREG-1:0] onehot(input logic [SEL_W-1:0] s);
    logic [NREG-1:0] v;
    v    = '0;
    v[s] = 1'b1;
    return v;
  endfunction

`ifdef ZERO_REG_WRITE_PROTECT_EN
  assign wen_a = WenA && (SelA != '0);
  assign wen_b = WenB && (SelB != '0);
`else
  assign wen_a = WenA;
  assign wen_b = WenB;
`endif

  assign ReadyB = (state == EMPTY);

  always_comb begin
    mask_a    = wen_a ? onehot(SelA) : '0;
    mask_b    = wen_b ? onehot(SelB) : '0;
    mask_h    = onehot(hold_sel);
    collide   = wen_a && wen_b && (SelA == SelB);
    a_on_hold = wen_a && (SelA == hold_sel);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state        <= EMPTY;
      hold_sel     <= '0;
      hold_data    <= '0;
      Load_Out     <= '0;
      Load_Src     <= '0;
      DataA_Out    <= '0;
      DataB_Out    <= '0;
      Conflict_Cnt <= '0;
    end else begin
      Load_Out <= '0;
      Load_Src <= '0;
      if (wen_a) DataA_Out <= DataA;
      case (state)
        EMPTY: begin
          if (collide) begin
            // A goes now, B waits a cycle so the register ends with B's data
            Load_Out  <= mask_a;
            hold_sel  <= SelB;
            hold_data <= DataB;
            state     <= HELD;
            if (Conflict_Cnt != 8'hFF) Conflict_Cnt <= Conflict_Cnt + 8'd1;
          end else begin
            Load_Out <= mask_a | mask_b;
            Load_Src <= mask_b;
            if (wen_b) DataB_Out <= DataB;
          end
        end
        HELD: begin
          if (a_on_hold) begin
            Load_Out <= mask_a;
          end else begin
            Load_Out  <= mask_a | mask_h;
            Load_Src  <= mask_h;
            DataB_Out <= hold_data;
            state     <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_dual_port_write_decoder.sv
// Self-checking bench for dual_port_write_decoder: directed scenarios plus random traffic
// compared against a queue-based model of pending port-B writes.
module tb_dual_port_write_decoder;

  logic        Clk;
  logic        Reset_n;
  logic [4:0]  SelA;
  logic        WenA;
  logic [31:0] DataA;
  logic [4:0]  SelB;
  logic        WenB;
  logic [31:0] DataB;
  logic        ReadyB;
  logic [31:0] Load_Out;
  logic [31:0] Load_Src;
  logic [31:0] DataA_Out;
  logic [31:0] DataB_Out;
  logic [7:0]  Conflict_Cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0]  sel;
    logic [31:0] data;
  } wr_t;

  wr_t         pend_q[$];
  logic [31:0] exp_load, exp_src, exp_da, exp_db;
  int          exp_cnt;
  logic        last_ready;

  dual_port_write_decoder #(.SEL_W(5), .DATA_W(32)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .SelA(SelA), .WenA(WenA), .DataA(DataA),
    .SelB(SelB), .WenB(WenB), .DataB(DataB),
    .ReadyB(ReadyB), .Load_Out(Load_Out), .Load_Src(Load_Src),
    .DataA_Out(DataA_Out), .DataB_Out(DataB_Out), .Conflict_Cnt(Conflict_Cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic dropped(input logic [4:0] s);
`ifdef ZERO_REG_WRITE_PROTECT_EN
    return (s == 5'd0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] bitof(input logic [4:0] s);
    return 32'd1 << s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend_q.delete();
    exp_load = '0; exp_src = '0; exp_da = '0; exp_db = '0; exp_cnt = 0;
  endtask

  // One clock: predict from the current inputs, clock, then compare registered outputs.
  task automatic step();
    logic        a, b;
    logic [31:0] issue, src;
    last_ready = (pend_q.size() == 0);
    chk("readyb", {31'd0, ReadyB}, {31'd0, last_ready});
    a = WenA && !dropped(SelA);
    b = WenB && !dropped(SelB) && last_ready;
    issue = '0;
    src   = '0;
    if (a) begin
      issue |= bitof(SelA);
      exp_da = DataA;
    end
    if (b) begin
      pend_q.push_back('{sel: SelB, data: DataB});
      if (a && SelA == SelB && exp_cnt < 255) exp_cnt++;
    end
    // the oldest B write goes out unless A is hitting the same register this cycle
    if (pend_q.size() > 0 && !(a && SelA == pend_q[0].sel)) begin
      issue |= bitof(pend_q[0].sel);
      src    = bitof(pend_q[0].sel);
      exp_db = pend_q[0].data;
      void'(pend_q.pop_front());
    end
    exp_load = issue;
    exp_src  = src;
    @(posedge Clk);
    #1;
    chk("load_out", Load_Out, exp_load);
    chk("load_src", Load_Src, exp_src);
    chk("data_a", DataA_Out, exp_da);
    chk("data_b", DataB_Out, exp_db);
    chk("conflict_cnt", {24'd0, Conflict_Cnt}, exp_cnt[31:0]);
  endtask

  task automatic idle();
    WenA = 1'b0;
    WenB = 1'b0;
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    #3;
    model_reset();
    chk("rst_load", Load_Out, 32'd0);
    chk("rst_src", Load_Src, 32'd0);
    chk("rst_da", DataA_Out, 32'd0);
    chk("rst_db", DataB_Out, 32'd0);
    chk("rst_cnt", {24'd0, Conflict_Cnt}, 32'd0);
    chk("rst_ready", {31'd0, ReadyB}, 32'd1);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
  endtask

  task automatic wr(input logic wa, input logic [4:0] sa, input logic [31:0] da,
                    input logic wb, input logic [4:0] sb, input logic [31:0] db);
    WenA = wa; SelA = sa; DataA = da;
    WenB = wb; SelB = sb; DataB = db;
  endtask

  initial begin
    logic       b_hold;
    Reset_n = 1'b1;
    wr(0, 0, 0, 0, 0, 0);
    model_reset();
    #2;
    do_reset();

    // independent A and B writes
    wr(1, 5'd3, 32'hAAAA0000, 1, 5'd7, 32'h5555FFFF);
    step();
    chk("r033_load", Load_Out, 32'h00000088);
    chk("r033_src", Load_Src, 32'h00000080);
    chk("r033_ready", {31'd0, ReadyB}, 32'd1);
    idle();
    step();

    // single collision
    do_reset();
    wr(1, 5'd5, 32'hCAFE0001, 1, 5'd5, 32'h00001234);
    step();
    chk("r034_load1", Load_Out, 32'h20);
    chk("r034_src1", Load_Src, 32'h0);
    idle();
    step();
    chk("r034_load2", Load_Out, 32'h20);
    chk("r034_src2", Load_Src, 32'h20);
    chk("r034_datab", DataB_Out, 32'h00001234);
    chk("r034_cnt", {24'd0, Conflict_Cnt}, 32'd1);

    // A keeps hitting the held register
    do_reset();
    wr(1, 5'd9, 32'h11110000, 1, 5'd9, 32'h99990000);
    step();
    for (int i = 0; i < 3; i++) begin
      wr(1, 5'd9, 32'h22220000 + i, 1, 5'd9, 32'h99990000);
      chk("r035_stall", {31'd0, ReadyB}, 32'd0);
      step();
      chk("r035_src_none", Load_Src, 32'd0);
    end
    idle();
    step();
    chk("r035_held_src", Load_Src, 32'h200);
    chk("r035_held_data", DataB_Out, 32'h99990000);
    chk("r035_cnt", {24'd0, Conflict_Cnt}, 32'd1);

    // random traffic, B source holds its request while stalled
    do_reset();
    b_hold = 1'b0;
    for (int i = 0; i < 400; i++) begin
      WenA  = 1'($urandom_range(0, 1));
      SelA  = 5'($urandom_range(0, 7));
      DataA = $urandom;
      if (!b_hold) begin
        WenB  = 1'($urandom_range(0, 1));
        SelB  = 5'($urandom_range(0, 7));
        DataB = $urandom;
      end
      step();
      b_hold = WenB && !last_ready;
    end
    idle();
    step();

    // counter saturation
    for (int i = 0; i < 300; i++) begin
      wr(1, 5'd12, $urandom, 1, 5'd12, $urandom);
      step();
      idle();
      step();
    end
    chk("r036_sat", {24'd0, Conflict_Cnt}, 32'd255);

    // reset while holding discards the deferred write
    wr(1, 5'd4, 32'hDEAD0000, 1, 5'd4, 32'hBEEF0000);
    step();
    idle();
    do_reset();
    step();
    chk("r037_no_late", Load_Out, 32'd0);
    wr(1, 5'd0, 32'h0BAD0BAD, 0, 5'd0, 32'd0);
    step();
`ifdef ZERO_REG_WRITE_PROTECT_EN
    chk("r037_zero_prot", Load_Out, 32'd0);
`else
    chk("r037_zero_wr", Load_Out, 32'd1);
`endif
    idle();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
